div_sched: RTL
==============

Name: div_sched

Overview:
- Sequencer for a multi-cycle iterative (radix-2 restoring) divider serving DIV/DIVU in the execute stage of the 5-stage MIPS pipeline.
- Accepts a divide request from stage E and freezes the pipeline via div_stall (feeds the hazard unit's divstall input) while iterating.
- Delivers quotient (LO) and remainder (HI) with a one-cycle result_valid pulse for the HI/LO write path.
- Supports annulment of an in-flight divide on exception or flush.

Parameters:
WIDTH, 32, operand/result width in bits.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
startE  input  1  divide instruction present in stage E this cycle.
signedE  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
dividendE  input  WIDTH  rs operand (post-forwarding); sampled with start.
divisorE  input  WIDTH  rt operand (post-forwarding); sampled with start.
annul  input  1  kill the in-flight divide (exception/flush).
div_stall  output  1  stall request to the hazard unit.
result_valid  output  1  one-cycle pulse; hi/lo valid this cycle.
hi  output  WIDTH  remainder.
lo  output  WIDTH  quotient.

Behaviour:
- States: IDLE, BUSY, ZERO, DONE.
- Reset (async, any state, mid-operation included): state=IDLE; counter=0; hi=0; lo=0; result_valid=0; div_stall=0; internal remainder/quotient/sign registers=0.
- IDLE:
  - startE=1, annul=0, divisorE!=0: latch |dividend|, |divisor| (absolute values only when signedE=1; raw otherwise). Latch quotient sign = sign(dividend) XOR sign(divisor), remainder sign = sign(dividend). Next state BUSY, counter=0.
  - startE=1, annul=0, divisorE==0: latch dividend; next state ZERO.
  - Otherwise remain in IDLE.
- BUSY: one quotient bit per cycle, MSB first.
  - Shift {rem,quot} left 1; trial-subtract the divisor from rem.
  - If no borrow: keep the difference and set quot LSB=1; else quot LSB=0.
  - Remainder datapath is WIDTH+1 bits wide so the borrow is unambiguous.
  - Counter increments each cycle; on counter==WIDTH-1, next state DONE.
- ZERO: single cycle; next state DONE with lo = all ones, hi = latched dividend (defined value for MIPS-unpredictable division by zero).
- DONE:
  - result_valid=1.
  - lo = quot, negated if the quotient sign is set; hi = rem, negated if the remainder sign is set (sign fix-ups apply only when signed).
  - hi/lo registered, held stable until the next DONE.
  - Next state IDLE.
  - startE is ignored in DONE: the same instruction is still in E.
- div_stall (combinational) = ((IDLE & startE) | BUSY | ZERO) & ~annul. It is 0 in DONE, letting the divide advance to M.
- Latency for start sampled in cycle T:
  - Nonzero divisor: BUSY during T+1..T+WIDTH; DONE and result_valid at T+WIDTH+1 (T+33 for WIDTH=32). div_stall is high T..T+WIDTH.
  - Zero divisor: ZERO at T+1; DONE at T+2.
- annul in any non-IDLE state: next state IDLE, no result_valid, hi/lo unchanged, div_stall low in that cycle.
- annul together with startE in IDLE: request not accepted.
- Back-to-back divides: a second start arriving in the cycle after DONE (state IDLE) is accepted normally.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0; no trap.
- Arithmetic is modulo 2^WIDTH throughout.

Test Plan:
- DIVU 100/7, start at T -> div_stall high T..T+32; at T+33 result_valid=1, lo=14, hi=2, div_stall=0; T+34 state IDLE, result_valid=0.
- DIV -7/2 (0xFFFFFFF9/2) -> at T+33 lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> ZERO at T+1; result_valid at T+2 with lo=0xFFFFFFFF, hi=5; div_stall high T..T+1.
- DIVU 1000/10 started, annul at T+10 -> div_stall low at T+10; IDLE at T+11; result_valid never pulses; hi/lo retain prior values.
- Two DIVUs back-to-back (second startE held through the first DONE, 40/3 then 9/4) -> first result lo=13, hi=1 at T+33, start ignored in DONE; second accepted at T+34, result lo=2, hi=1 at T+67.
- Assert rst at T+15 of a divide -> all outputs 0 immediately (asynchronous); after release, state IDLE and a new DIVU 6/3 completes with lo=2, hi=0.

Source files
------------

// File: rtl/div_sched_if.sv
// Handshake between the execute stage and the iterative divide sequencer.
// Stage E drives the request side; the divider returns stall, result strobe and HI/LO.
interface div_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic             startE;
  logic             signedE;
  logic [WIDTH-1:0] dividendE;
  logic [WIDTH-1:0] divisorE;
  logic             annul;
  logic             div_stall;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output startE, signedE, dividendE, divisorE, annul,
    input  div_stall, result_valid, hi, lo
  );

  modport slave (
    input  startE, signedE, dividendE, divisorE, annul,
    output div_stall, result_valid, hi, lo
  );
endinterface

// File: rtl/div_sched.sv
// Radix-2 restoring divide sequencer for DIV/DIVU: stalls the pipeline while
// iterating one quotient bit per cycle, then pulses result_valid with HI/LO.
module div_sched #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  div_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             rv_q, rv_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             a_neg;
  logic             b_neg;

  // Next-state and datapath for the sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rv_d    = 1'b0;

    // Extra top bit makes the trial-subtract borrow unambiguous.
    rem_sh = {rem_q, quot_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    a_neg  = bus.signedE & bus.dividendE[WIDTH-1];
    b_neg  = bus.signedE & bus.divisorE[WIDTH-1];

    unique case (state_q)
      IDLE: begin
        if (bus.startE && !bus.annul) begin
          rem_d = '0;
          cnt_d = '0;
          if (bus.divisorE != '0) begin
            quot_d  = a_neg ? (~bus.dividendE + 1'b1) : bus.dividendE;
            dvs_d   = b_neg ? (~bus.divisorE + 1'b1) : bus.divisorE;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = BUSY;
          end else begin
            quot_d  = bus.dividendE;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = ZERO;
          end
        end
      end
      BUSY: begin
        if (bus.annul) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          rem_d  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            rv_d    = 1'b1;
            lo_d    = qneg_q ? (~quot_d + 1'b1) : quot_d;
            hi_d    = rneg_q ? (~rem_d + 1'b1) : rem_d;
          end
        end
      end
      ZERO: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          rv_d    = 1'b1;
          lo_d    = '1;
          hi_d    = quot_q;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rv_q    <= rv_d;
    end
  end

  // Stall must drop in DONE so the divide can advance to M.
  assign bus.div_stall    = (((state_q == IDLE) & bus.startE) | (state_q == BUSY) |
                             (state_q == ZERO)) & ~bus.annul;
  assign bus.result_valid = rv_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule
